// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared types and constants for beat bus consumers
package beat_pkg;

  localparam int NBEATS_DEF = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    LOCKED = 2'b01,
    FAULT  = 2'b10
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_ORDER = 2'b10;
  localparam logic [1:0] ERR_DEAD  = 2'b11;

endpackage

// File: rtl/beat_monitor_if.sv
// rtl/beat_monitor_if.sv - beat bus input and step/cycle status outputs
interface beat_monitor_if #(
  parameter int NBEATS = 8,
  parameter int IDX_W  = 3,
  parameter int CYC_W  = 16
);
  logic [NBEATS-1:0] beat;
  logic              clr_err;
  logic [IDX_W-1:0]  step_idx;
  logic              step_valid;
  logic              cycle_start;
  logic              cycle_end;
  logic [CYC_W-1:0]  cycle_cnt;
  logic              locked;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output beat, clr_err,
    input  step_idx, step_valid, cycle_start, cycle_end, cycle_cnt, locked, err, err_code
  );

  modport slave (
    input  beat, clr_err,
    output step_idx, step_valid, cycle_start, cycle_end, cycle_cnt, locked, err, err_code
  );
endinterface

// File: rtl/beat_enc.sv
// rtl/beat_enc.sv - one-hot beat to index encoder with one-hot/zero flags
module beat_enc #(
  parameter int NBEATS = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NBEATS-1:0] beat,
  output logic [IDX_W-1:0]  idx,
  output logic              is_onehot,
  output logic              is_zero
);

  // OR of set-bit positions; only meaningful when is_onehot
  always_comb begin
    idx = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat[i]) idx = idx | IDX_W'(i);
    end
  end

  assign is_zero   = (beat == '0);
  assign is_onehot = !is_zero && ((beat & (beat - NBEATS'(1))) == '0);

endmodule

// File: rtl/beat_monitor.sv
// rtl/beat_monitor.sv - beat ring consumer: step index, cycle counting, sequence fault detection
module beat_monitor
  import beat_pkg::*;
#(
  parameter int NBEATS = NBEATS_DEF,
  parameter int IDX_W  = 3,
  parameter int CYC_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  beat_monitor_if.slave  bus
);

  localparam logic [NBEATS-1:0] T0   = NBEATS'(1);
  localparam logic [IDX_W-1:0]  LAST = IDX_W'(NBEATS - 1);

  state_t            state;
  logic [NBEATS-1:0] prev;
  logic [NBEATS-1:0] expected;
  logic [IDX_W-1:0]  idx;
  logic              is_onehot;
  logic              is_zero;

  logic [IDX_W-1:0]  step_idx;
  logic              step_valid;
  logic              cycle_start;
  logic              cycle_end;
  logic [CYC_W-1:0]  cycle_cnt;
  logic              locked;
  logic              err;
  logic [1:0]        err_code;

  beat_enc #(.NBEATS(NBEATS), .IDX_W(IDX_W)) u_enc (
    .beat      (bus.beat),
    .idx       (idx),
    .is_onehot (is_onehot),
    .is_zero   (is_zero)
  );

  assign expected = {prev[NBEATS-2:0], prev[NBEATS-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      prev        <= '0;
      step_idx    <= '0;
      step_valid  <= 1'b0;
      cycle_start <= 1'b0;
      cycle_end   <= 1'b0;
      cycle_cnt   <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      prev        <= bus.beat;
      step_valid  <= 1'b0;
      cycle_start <= 1'b0;
      cycle_end   <= 1'b0;
      case (state)
        HUNT: begin
          if (bus.beat == T0) begin
            state       <= LOCKED;
            locked      <= 1'b1;
            step_idx    <= '0;
            step_valid  <= 1'b1;
            cycle_start <= 1'b1;
            cycle_cnt   <= cycle_cnt + CYC_W'(1);
          end
        end
        LOCKED: begin
          if (bus.beat == expected) begin
            step_idx    <= idx;
            step_valid  <= 1'b1;
            cycle_start <= (idx == '0);
            cycle_end   <= (idx == LAST);
            if (idx == '0) cycle_cnt <= cycle_cnt + CYC_W'(1);
          end else begin
            state    <= FAULT;
            locked   <= 1'b0;
            err      <= 1'b1;
            err_code <= is_zero ? ERR_DEAD : (!is_onehot ? ERR_MULTI : ERR_ORDER);
          end
        end
        FAULT: begin
          // a T0 coincident with the clear is not accepted; relock waits a full ring
          if (bus.clr_err) begin
            state    <= HUNT;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign bus.step_idx    = step_idx;
  assign bus.step_valid  = step_valid;
  assign bus.cycle_start = cycle_start;
  assign bus.cycle_end   = cycle_end;
  assign bus.cycle_cnt   = cycle_cnt;
  assign bus.locked      = locked;
  assign bus.err         = err;
  assign bus.err_code    = err_code;

endmodule

// File: tb/tb_beat_monitor.sv
// tb/tb_beat_monitor.sv - randomized and directed bench for beat_monitor against a position-level model
module tb_beat_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] beat = 8'h00;
  logic       clr_err = 1'b0;

  int checks = 0;
  int errors = 0;

  beat_monitor_if #(.NBEATS(8), .IDX_W(3), .CYC_W(16)) bus ();
  beat_monitor_if #(.NBEATS(8), .IDX_W(3), .CYC_W(4))  bus4 ();

  assign bus.beat     = beat;
  assign bus.clr_err  = clr_err;
  assign bus4.beat    = beat;
  assign bus4.clr_err = clr_err;

  beat_monitor #(.NBEATS(8), .IDX_W(3), .CYC_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  beat_monitor #(.NBEATS(8), .IDX_W(3), .CYC_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  // model: tracks the last accepted position rather than the raw previous beat
  logic        m_locked, m_fault, m_sv, m_cs, m_ce;
  logic [2:0]  m_idx;
  logic [15:0] m_cnt;
  logic [1:0]  m_code;

  function automatic void model_reset();
    m_locked = 0; m_fault = 0; m_sv = 0; m_cs = 0; m_ce = 0;
    m_idx = 0; m_cnt = 0; m_code = 0;
  endfunction

  function automatic void model_step(input logic [7:0] b, input logic c);
    int nxt;
    m_sv = 0; m_cs = 0; m_ce = 0;
    if (m_fault) begin
      if (c) begin m_fault = 0; m_code = 0; end
    end else if (!m_locked) begin
      if (b == 8'h01) begin
        m_locked = 1; m_idx = 0; m_sv = 1; m_cs = 1; m_cnt = m_cnt + 1;
      end
    end else begin
      nxt = (int'(m_idx) + 1) % 8;
      if (b == (8'h01 << nxt)) begin
        m_idx = 3'(nxt); m_sv = 1; m_cs = (nxt == 0); m_ce = (nxt == 7);
        if (nxt == 0) m_cnt = m_cnt + 1;
      end else begin
        m_locked = 0; m_fault = 1;
        m_code = (b == 0) ? 2'b11 : (($countones(b) > 1) ? 2'b01 : 2'b10);
      end
    end
  endfunction

  task automatic drive(input logic [7:0] b, input logic c);
    beat = b; clr_err = c;
    @(posedge clk); #1;
    model_step(b, c);
  endtask

  task automatic do_reset();
    rst_n = 0; beat = 0; clr_err = 0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.step_idx, bus.step_valid, bus.cycle_start, bus.cycle_end, bus.cycle_cnt,
         bus.locked, bus.err, bus.err_code, bus4.cycle_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got idx=%0d sv=%b cs=%b ce=%b cnt=%0d lk=%b err=%b code=%b exp all zero",
               bus.step_idx, bus.step_valid, bus.cycle_start, bus.cycle_end, bus.cycle_cnt,
               bus.locked, bus.err, bus.err_code);
    end
  endtask

  task automatic test_ring();
    do_reset();
    for (int p = 0; p < 9; p++) begin
      drive(8'h01 << (p % 8), 0);
      if (p == 0) begin
        checks++;
        if ({bus.locked, bus.step_idx, bus.cycle_start, bus.cycle_cnt} !== {1'b1, 3'd0, 1'b1, 16'd1}) begin
          errors++;
          $display("FAIL ring_first got lk=%b idx=%0d cs=%b cnt=%0d exp lk=1 idx=0 cs=1 cnt=1",
                   bus.locked, bus.step_idx, bus.cycle_start, bus.cycle_cnt);
        end
      end
      if (p == 7) begin
        checks++;
        if ({bus.step_idx, bus.cycle_end, bus.step_valid} !== {3'd7, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL ring_eighth got idx=%0d ce=%b sv=%b exp idx=7 ce=1 sv=1",
                   bus.step_idx, bus.cycle_end, bus.step_valid);
        end
      end
      if (p == 8) begin
        checks++;
        if (bus.cycle_cnt !== 16'd2) begin
          errors++;
          $display("FAIL ring_ninth_cnt got %0d exp 2", bus.cycle_cnt);
        end
      end
    end
  endtask

  task automatic test_multi_hot();
    do_reset();
    drive(8'h01, 0); drive(8'h02, 0); drive(8'h04, 0);
    drive(8'h18, 0);
    checks++;
    if ({bus.err, bus.err_code, bus.locked, bus.step_valid, bus.step_idx} !== {1'b1, 2'b01, 1'b0, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL multi_hot got err=%b code=%b lk=%b sv=%b idx=%0d exp err=1 code=01 lk=0 sv=0 idx=2",
               bus.err, bus.err_code, bus.locked, bus.step_valid, bus.step_idx);
    end
  endtask

  task automatic test_order_and_clear();
    logic [15:0] cnt_before;
    do_reset();
    drive(8'h01, 0);
    drive(8'h04, 0);
    checks++;
    if ({bus.err, bus.err_code} !== {1'b1, 2'b10}) begin
      errors++;
      $display("FAIL order_code got err=%b code=%b exp err=1 code=10", bus.err, bus.err_code);
    end
    cnt_before = bus.cycle_cnt;
    drive(8'h80, 1);
    checks++;
    if ({bus.err, bus.err_code, bus.locked, bus.step_valid} !== 5'b0) begin
      errors++;
      $display("FAIL clear_to_hunt got err=%b code=%b lk=%b sv=%b exp all 0",
               bus.err, bus.err_code, bus.locked, bus.step_valid);
    end
    drive(8'h01, 0);
    checks++;
    if ({bus.locked, bus.cycle_start, bus.cycle_cnt} !== {1'b1, 1'b1, 16'(cnt_before + 1)}) begin
      errors++;
      $display("FAIL relock got lk=%b cs=%b cnt=%0d exp lk=1 cs=1 cnt=%0d",
               bus.locked, bus.cycle_start, bus.cycle_cnt, cnt_before + 1);
    end
  endtask

  task automatic test_dead_and_hunt();
    do_reset();
    drive(8'h01, 0); drive(8'h02, 0);
    drive(8'h00, 0);
    checks++;
    if ({bus.err, bus.err_code, bus.step_idx} !== {1'b1, 2'b11, 3'd1}) begin
      errors++;
      $display("FAIL dead_code got err=%b code=%b idx=%0d exp err=1 code=11 idx=1",
               bus.err, bus.err_code, bus.step_idx);
    end
    drive(8'h01, 1);
    checks++;
    if ({bus.locked, bus.err, bus.step_valid, bus.cycle_cnt} !== {1'b0, 1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL clear_with_t0 got lk=%b err=%b sv=%b cnt=%0d exp lk=0 err=0 sv=0 cnt=1",
               bus.locked, bus.err, bus.step_valid, bus.cycle_cnt);
    end
    drive(8'h40, 0);
    drive(8'h80, 0);
    checks++;
    if ({bus.locked, bus.err, bus.err_code} !== 4'b0) begin
      errors++;
      $display("FAIL hunt_ignores got lk=%b err=%b code=%b exp all 0", bus.locked, bus.err, bus.err_code);
    end
    drive(8'h01, 0);
    checks++;
    if ({bus.locked, bus.step_valid, bus.cycle_cnt} !== {1'b1, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL hunt_lock got lk=%b sv=%b cnt=%0d exp lk=1 sv=1 cnt=2",
               bus.locked, bus.step_valid, bus.cycle_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 8; p++) begin
        drive(8'h01 << p, 0);
        if (p == 0) begin
          checks++;
          if ({bus4.cycle_cnt, bus4.err} !== {m_cnt[3:0], 1'b0}) begin
            errors++;
            $display("FAIL wrap_cnt ring %0d got cnt=%0d err=%b exp cnt=%0d err=0",
                     r, bus4.cycle_cnt, bus4.err, m_cnt[3:0]);
          end
          if (r == 15) begin
            checks++;
            if (bus4.cycle_cnt !== 4'd0) begin
              errors++;
              $display("FAIL wrap_to_zero got %0d exp 0", bus4.cycle_cnt);
            end
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int p = 0; p < 6; p++) drive(8'h01 << p, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.step_idx, bus.step_valid, bus.cycle_start, bus.cycle_end, bus.cycle_cnt,
         bus.locked, bus.err, bus.err_code, bus4.cycle_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got idx=%0d sv=%b cnt=%0d lk=%b exp all zero before edge",
               bus.step_idx, bus.step_valid, bus.cycle_cnt, bus.locked);
    end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       c;
    int         r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 15);
      if (m_locked && r > 1) b = 8'h01 << ((int'(m_idx) + 1) % 8);
      else if (r < 2)        b = 8'($urandom_range(0, 255));
      else                   b = 8'h01 << $urandom_range(0, 7);
      c = ($urandom_range(0, 3) == 0);
      drive(b, c);
      checks++;
      if ({bus.step_idx, bus.step_valid, bus.cycle_start, bus.cycle_end, bus.cycle_cnt,
           bus.locked, bus.err, bus.err_code, bus4.cycle_cnt} !==
          {m_idx, m_sv, m_cs, m_ce, m_cnt, m_locked, m_fault, m_code, m_cnt[3:0]}) begin
        errors++;
        $display("FAIL random step %0d beat=%h clr=%b got idx=%0d sv=%b cs=%b ce=%b cnt=%0d lk=%b err=%b code=%b cnt4=%0d exp idx=%0d sv=%b cs=%b ce=%b cnt=%0d lk=%b err=%b code=%b",
                 n, b, c, bus.step_idx, bus.step_valid, bus.cycle_start, bus.cycle_end, bus.cycle_cnt,
                 bus.locked, bus.err, bus.err_code, bus4.cycle_cnt,
                 m_idx, m_sv, m_cs, m_ce, m_cnt, m_locked, m_fault, m_code);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ring();
    test_multi_hot();
    test_order_and_clear();
    test_dead_and_hunt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
